// File: rtl/ecc_line_encoder_if.sv
// Write-request and SRAM-write handshake bundle for the ECC line encoder.
// The slave modport is the encoder's view; master is the requester/SRAM side.
interface ecc_line_encoder_if #(
    parameter int DIVISIONS = 1,
    parameter int SIZE      = 1,
    parameter int TAG_WIDTH = 1
);
    localparam int BLOCK_SIZE     = SIZE / DIVISIONS;
    localparam int BLOCK_SIZE_ECC = $clog2(BLOCK_SIZE) + BLOCK_SIZE + 2;
    localparam int TAG_ECC        = $clog2(TAG_WIDTH) + TAG_WIDTH + 2;
    localparam int LINE_WIDTH     = TAG_ECC + DIVISIONS * BLOCK_SIZE_ECC + 2;
    localparam int MAX_ECC        = (BLOCK_SIZE_ECC > TAG_ECC) ? BLOCK_SIZE_ECC : TAG_ECC;
    localparam int DIV_WIDTH      = $clog2(DIVISIONS + 1);
    localparam int BIT_WIDTH      = $clog2(MAX_ECC);

    logic                  req_valid_i;
    logic                  req_ready_o;
    logic [SIZE-1:0]       req_data_i;
    logic [TAG_WIDTH-1:0]  req_tag_i;
    logic                  req_dirty_i;
    logic                  req_vld_i;
    logic                  inj_en_i;
    logic [DIV_WIDTH-1:0]  inj_div_i;
    logic [BIT_WIDTH-1:0]  inj_bit_i;
    logic                  inj_dbl_i;
    logic                  out_valid_o;
    logic                  out_ready_i;
    logic [LINE_WIDTH-1:0] out_line_o;
    logic [15:0]           inj_cnt_o;

    modport slave (
        input  req_valid_i, req_data_i, req_tag_i, req_dirty_i, req_vld_i,
        input  inj_en_i, inj_div_i, inj_bit_i, inj_dbl_i, out_ready_i,
        output req_ready_o, out_valid_o, out_line_o, inj_cnt_o
    );

    modport master (
        output req_valid_i, req_data_i, req_tag_i, req_dirty_i, req_vld_i,
        output inj_en_i, inj_div_i, inj_bit_i, inj_dbl_i, out_ready_i,
        input  req_ready_o, out_valid_o, out_line_o, inj_cnt_o
    );
endinterface

// File: rtl/ecc_line_encoder.sv
// Write-side Hsiao ECC encoder for cache-line SRAMs with a 2-entry elastic
// buffer and a verification-only single/double bit error-injection path.

// Codeword layout: data in [K-1:0], check bits in [K+R-1:K].
module ecc_line_encoder_hsiao_enc #(
    parameter int K = 1
) (
    input  logic [K-1:0]             data,
    output logic [K+$clog2(K)+1:0]   code
);
    localparam int R = $clog2(K) + 2;

    // Data column i is the i-th R-bit pattern of odd weight >= 3 (ascending
    // weight, then value); tiny codes fall back to even-weight patterns.
    function automatic logic [R-1:0] hsiao_col(input int idx);
        int n;
        logic [R-1:0] res;
        n   = 0;
        res = '0;
        for (int pass = 0; pass < 2; pass++) begin
            for (int w = (pass == 0) ? 3 : 2; w <= R; w += 2) begin
                for (int v = 1; v < (1 << R); v++) begin
                    if ($countones(v) == w) begin
                        if (n == idx) res = R'(v);
                        n++;
                    end
                end
            end
        end
        return res;
    endfunction

    logic [R-1:0] cols [K];
    logic [R-1:0] parity;

    for (genvar i = 0; i < K; i++) begin : g_col
        localparam logic [R-1:0] COL = hsiao_col(i);
        assign cols[i] = COL;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        parity = '0;
        for (int i = 0; i < K; i++) begin
            if (data[i]) parity ^= cols[i];
        end
    end

    assign code = {parity, data};
endmodule

module ecc_line_encoder #(
    parameter int DIVISIONS = 1,
    parameter int SIZE      = 1,
    parameter int TAG_WIDTH = 1
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    ecc_line_encoder_if.slave   bus
);
    localparam int BLOCK_SIZE     = SIZE / DIVISIONS;
    localparam int BLOCK_SIZE_ECC = $clog2(BLOCK_SIZE) + BLOCK_SIZE + 2;
    localparam int TAG_ECC        = $clog2(TAG_WIDTH) + TAG_WIDTH + 2;

    typedef struct packed {
        logic [TAG_ECC-1:0]                  tag;
        logic [DIVISIONS*BLOCK_SIZE_ECC-1:0] data;
        logic                                dirty;
        logic                                valid;
    } line_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_e;

    logic [DIVISIONS-1:0][BLOCK_SIZE_ECC-1:0] enc_data, data_flip;
    logic [TAG_ECC-1:0] enc_tag, tag_flip;
    logic  inj_hit;
    int    inj_bit, inj_div, bit_next_data, bit_next_tag;
    line_t new_line, out_q, skid_q;

    state_e state_q, state_d;
    logic   accept, xfer;
    logic   req_ready, out_valid;
    logic   load_out_new, load_out_skid, load_skid;
    logic [15:0] inj_cnt_q;

    for (genvar j = 0; j < DIVISIONS; j++) begin : g_div
        ecc_line_encoder_hsiao_enc #(.K(BLOCK_SIZE)) u_enc (
            .data (bus.req_data_i[j*BLOCK_SIZE +: BLOCK_SIZE]),
            .code (enc_data[j])
        );
    end

    ecc_line_encoder_hsiao_enc #(.K(TAG_WIDTH)) u_tag_enc (
        .data (bus.req_tag_i),
        .code (enc_tag)
    );

    assign inj_bit       = int'(bus.inj_bit_i);
    assign inj_div       = int'(bus.inj_div_i);
    assign bit_next_data = (inj_bit == BLOCK_SIZE_ECC - 1) ? 0 : inj_bit + 1;
    assign bit_next_tag  = (inj_bit == TAG_ECC - 1) ? 0 : inj_bit + 1;

    // Out-of-range division or bit index silently drops the injection.
    always_comb begin
        data_flip = '0;
        tag_flip  = '0;
        inj_hit   = 1'b0;
        if (bus.inj_en_i) begin
            if (inj_div == DIVISIONS) begin
                if (inj_bit < TAG_ECC) begin
                    inj_hit = 1'b1;
                    for (int k = 0; k < TAG_ECC; k++) begin
                        if (k == inj_bit || (bus.inj_dbl_i && k == bit_next_tag)) tag_flip[k] = 1'b1;
                    end
                end
            end else if (inj_div < DIVISIONS && inj_bit < BLOCK_SIZE_ECC) begin
                inj_hit = 1'b1;
                for (int j = 0; j < DIVISIONS; j++) begin
                    for (int k = 0; k < BLOCK_SIZE_ECC; k++) begin
                        if (j == inj_div && (k == inj_bit || (bus.inj_dbl_i && k == bit_next_data)))
                            data_flip[j][k] = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        new_line.tag   = enc_tag ^ tag_flip;
        new_line.data  = enc_data ^ data_flip;
        new_line.dirty = bus.req_dirty_i;
        new_line.valid = bus.req_vld_i;
    end

    // Handshakes decode straight from the state register, so req_ready has no
    // combinational dependence on out_ready_i.
    assign accept = bus.req_valid_i & (state_q != FULL);
    assign xfer   = (state_q != EMPTY) & bus.out_ready_i;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state_q <= EMPTY;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            EMPTY: if (accept) state_d = ONE;
            ONE: begin
                if (accept && !xfer)      state_d = FULL;
                else if (!accept && xfer) state_d = EMPTY;
            end
            FULL:    if (xfer) state_d = ONE;
            default: state_d = EMPTY;
        endcase
    end

    always_comb begin
        req_ready     = 1'b1;
        out_valid     = 1'b0;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        unique case (state_q)
            EMPTY: load_out_new = accept;
            ONE: begin
                out_valid    = 1'b1;
                load_out_new = accept && xfer;
                load_skid    = accept && !xfer;
            end
            FULL: begin
                out_valid     = 1'b1;
                req_ready     = 1'b0;
                load_out_skid = xfer;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)            out_q <= '0;
        else if (load_out_new)  out_q <= new_line;
        else if (load_out_skid) out_q <= skid_q;
    end

    // NOTE: skid data is not reset; its validity lives entirely in state_q.
    always_ff @(posedge clk_i) begin
        if (load_skid) skid_q <= new_line;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            inj_cnt_q <= '0;
        else if (accept && inj_hit && inj_cnt_q != 16'hFFFF)
            inj_cnt_q <= inj_cnt_q + 16'd1;
    end

    assign bus.req_ready_o = req_ready;
    assign bus.out_valid_o = out_valid;
    assign bus.out_line_o  = out_q;
    assign bus.inj_cnt_o   = inj_cnt_q;
endmodule
